// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC, single-outstanding imem fetch FSM and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  if_stage_if.master        bus,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic [5:0]        ifid_op_code
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, hold_instr, hold_nxt, word;
  logic        discard, discard_nxt, deliver;
  assign bus.imem_req  = state == REQ;
  assign bus.imem_addr = pc;
  assign ifid_op_code  = ifid_instr[31:26];
  // A redirect coinciding with the in-flight word consumes it, so no discard is left pending.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    hold_nxt    = hold_instr;
    deliver     = 1'b0;
    word        = hold_instr;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: if (bus.imem_ack) begin
        state_nxt   = WAIT;
        discard_nxt = redirect;
      end
      WAIT: if (bus.imem_rvalid) begin
        discard_nxt = 1'b0;
        word        = bus.imem_rdata;
        if (discard || redirect) state_nxt = REQ;
        else if (!stall) begin
          deliver   = 1'b1;
          state_nxt = REQ;
        end else begin
          hold_nxt  = bus.imem_rdata;
          state_nxt = HOLD;
        end
      end else if (redirect) discard_nxt = 1'b1;
      HOLD: if (redirect) state_nxt = REQ;
      else if (!stall) begin
        deliver   = 1'b1;
        state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    pc_nxt = redirect ? {redirect_pc[31:2], 2'b00} : deliver ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      hold_instr <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      discard    <= discard_nxt;
      hold_instr <= hold_nxt;
      if (redirect) begin
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end else if (deliver) begin
        ifid_valid <= 1'b1;
        ifid_instr <= word;
        ifid_pc4   <= pc + 32'd4;
      end else if (!stall) begin
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench against a transaction-level reference model.
module tb_if_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4;
  logic [5:0]  ifid_op_code;
  int total = 0, bad = 0;
  int p_stall = 0, p_redir = 0, ack_lo = 0, ack_hi = 0, rv_lo = 0, rv_hi = 0;
  int f_stall = -1, f_redir = -1;
  logic [31:0] f_rp = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int rv_wait = 0, ack_wait = 0;
  logic        m_started, m_out, m_stale, m_park_v, e_valid, saw_wrap = 1'b0;
  logic [31:0] m_pc, m_park, e_instr, e_pc4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  if_stage_if bus();
  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_op_code(ifid_op_code)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_park_v = 1'b0; m_park = '0;
    m_pc = RST_PC; e_valid = 1'b0; e_instr = '0; e_pc4 = '0;
  endtask

  // Fetch seen as: not started / request outstanding (maybe stale) / word parked / ready to request.
  task automatic mstep();
    logic        dlv = 1'b0;
    logic [31:0] w = m_park, old = m_pc;
    if (!m_started) m_started = 1'b1;
    else if (m_park_v) begin
      if (redirect) m_park_v = 1'b0;
      else if (!stall) begin dlv = 1'b1; m_park_v = 1'b0; end
    end else if (m_out) begin
      if (bus.imem_rvalid) begin
        m_out = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (!redirect) begin
          if (!stall) begin dlv = 1'b1; w = bus.imem_rdata; end
          else begin m_park_v = 1'b1; m_park = bus.imem_rdata; end
        end
      end else if (redirect) m_stale = 1'b1;
    end else if (bus.imem_ack) begin
      m_out = 1'b1; m_stale = redirect;
    end
    m_pc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : dlv ? m_pc + 32'd4 : m_pc;
    if (redirect) begin e_valid = 1'b0; e_instr = '0; end
    else if (dlv) begin
      e_valid = 1'b1; e_instr = w; e_pc4 = old + 32'd4;
      if (old == 32'hFFFF_FFFC) saw_wrap = 1'b1;
    end else if (!stall) begin e_valid = 1'b0; e_instr = '0; end
  endtask

  task automatic step();
    logic        rq;
    logic [31:0] ad;
    @(negedge clk);
    chk("req", {31'b0, bus.imem_req}, {31'b0, m_started && !m_out && !m_park_v});
    chk("addr", bus.imem_addr, m_pc);
    chk("valid", {31'b0, ifid_valid}, {31'b0, e_valid});
    chk("instr", ifid_instr, e_instr);
    chk("op_code", {26'b0, ifid_op_code}, {26'b0, e_instr[31:26]});
    if (e_valid) chk("pc4", ifid_pc4, e_pc4);
    rq = bus.imem_req;
    ad = bus.imem_addr;
    stall = (f_stall >= 0) ? (f_stall != 0) : ($urandom_range(99) < p_stall);
    redirect = (f_redir >= 0) ? (f_redir != 0) : ($urandom_range(99) < p_redir);
    redirect_pc = (f_redir >= 0) ? f_rp :
                  ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom_range(1023);
    bus.imem_ack = rq && !pend && ack_wait == 0;
    bus.imem_rvalid = pend && rv_wait == 0;
    bus.imem_rdata = bus.imem_rvalid ? mem_word(pend_addr) : $urandom;
    @(posedge clk);
    if (!rst_n) mreset(); else mstep();
    if (bus.imem_ack) begin
      pend = 1'b1; pend_addr = ad;
      rv_wait = $urandom_range(rv_hi, rv_lo);
      ack_wait = $urandom_range(ack_hi, ack_lo);
    end else if (bus.imem_rvalid) pend = 1'b0;
    else begin
      if (pend && rv_wait > 0) rv_wait--;
      if (rq && !pend && ack_wait > 0) ack_wait--;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'h0);
    chk({tag, "_addr"}, bus.imem_addr, RST_PC);
    chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, "_instr"}, ifid_instr, 32'h0);
    chk({tag, "_pc4"}, ifid_pc4, 32'h0);
    chk({tag, "_op"}, {26'b0, ifid_op_code}, 32'h0);
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 40 && !m_out; i++) step();
    chk(tag, {31'b0, m_out}, 32'h1);
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    mreset();
    repeat (2) step();
    #1 chk_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 20 && !(m_out && pend && rv_wait == 0); i++) step();
    chk("stall_setup", {31'b0, m_out}, 32'h1);
    f_stall = 1; repeat (4) step();
    f_stall = 0; repeat (4) step();
    wait_out("redir_setup");
    f_redir = 1; f_rp = 32'h100; step();
    f_redir = 0; repeat (6) step();
    wait_out("both_setup");
    f_redir = 1; f_stall = 1; f_rp = 32'h103; step();
    f_redir = 0; f_stall = 0; repeat (6) step();
    f_redir = 1; f_rp = 32'hFFFF_FFFC; step();
    f_redir = 0; repeat (8) step();
    chk("wrap_seen", {31'b0, saw_wrap}, 32'h1);
    f_stall = -1; f_redir = -1; p_stall = 30; p_redir = 8; ack_hi = 3; rv_hi = 3;
    repeat (3000) step();
    f_stall = 0; f_redir = 0; ack_lo = 0; ack_hi = 0; rv_lo = 4; rv_hi = 4;
    wait_out("arst_setup");
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    mreset();
    repeat (2) step();
    #1 rst_n = 1'b1;
    repeat (20) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
